// File: rtl/pololu_stepper_pkg.sv
// Shared register map, CTRL bit positions, motion states and WSTRB merge helper.
package pololu_stepper_pkg;

  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_PERIOD  = 5'h04;
  localparam logic [4:0] REG_STEPS   = 5'h08;
  localparam logic [4:0] REG_SCRATCH = 5'h0C;
  localparam logic [4:0] REG_STATUS  = 5'h10;
  localparam logic [4:0] REG_REMAIN  = 5'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_MS_LO = 2;
  localparam int CTRL_MS_HI = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } motion_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] mask;
    mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/stepper_pulse_gen.sv
// Fixed-rate STEP pulse engine: runs remain pulses, PULSE_W high, eff_period apart.
// Load starts a move from idle or reloads remain mid-move; EN low aborts on the next clock.
module stepper_pulse_gen
  import pololu_stepper_pkg::*;
#(
  parameter int PULSE_W = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] period,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        step,
  output logic        busy,
  output logic        done_pulse,
  output logic [31:0] remain
);

  localparam logic [31:0] MIN_PER = 32'(2 * PULSE_W);
  localparam logic [31:0] HI_LAST = 32'(PULSE_W - 1);

  motion_state_e state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   per_q, per_d;
  logic [31:0]   remain_q, remain_d;
  logic [31:0]   eff_period;

  // Clamp keeps the driver's minimum low time even for tiny PERIOD values.
  assign eff_period = (period > MIN_PER) ? period : MIN_PER;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    remain_d   = remain_q;
    done_pulse = 1'b0;
    if (state_q != IDLE && cnt_q != '1) cnt_d = cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (load && en && load_val != '0) begin
          state_d  = HIGH;
          cnt_d    = '0;
          per_d    = eff_period;
          remain_d = load_val;
        end
      end
      HIGH: begin
        if (cnt_q >= HI_LAST) begin
          state_d = LOW;
          if (remain_q != '0) remain_d = remain_q - 32'd1;
        end
      end
      LOW: begin
        if (cnt_q >= per_q - 32'd1) begin
          if (remain_q != '0) begin
            state_d = HIGH;
            cnt_d   = '0;
            per_d   = eff_period;
          end else begin
            state_d    = IDLE;
            done_pulse = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && load) remain_d = load_val;
    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      remain_d   = '0;
      done_pulse = 1'b0;
    end
  end

  assign step   = (state_q == HIGH);
  assign busy   = (state_q != IDLE);
  assign remain = remain_q;

endmodule

// File: rtl/pololu_stepper_axi_slave.sv
// AXI4-Lite register file driving STEP/DIR/ENABLE_N/MS; one accept cycle, B/R held until ready.
// A pending B (or R) response blocks the next write (or read) from being accepted.
module pololu_stepper_axi_slave
  import pololu_stepper_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int PULSE_W            = 100
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              step_o,
  output logic                              dir_o,
  output logic                              enable_n_o,
  output logic [2:0]                        ms_o
);

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [2:0]  araddr_q;
  logic [31:0] rdata_q, rd_val;
  logic [31:0] ctrl_q, period_q, steps_q, scratch_q;
  logic        done_q, busy, done_pulse, step_load;
  logic [31:0] remain, steps_merged;
  logic [4:0]  wr_off, rd_off;
  logic        wr_fire, rd_fire;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_fire      = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
  assign rd_fire      = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
  assign wr_off       = {S_AXI_AWADDR[4:2], 2'b00};
  assign rd_off       = {araddr_q, 2'b00};
  assign steps_merged = apply_wstrb(steps_q, S_AXI_WDATA, S_AXI_WSTRB);
  assign step_load    = wr_fire && (wr_off == REG_STEPS) && (|S_AXI_WSTRB);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
    end else begin
      awready_q <= wr_fire;
      if (awready_q)         bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= rd_fire;
      if (rd_fire) araddr_q <= S_AXI_ARADDR[4:2];
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      period_q  <= '0;
      steps_q   <= '0;
      scratch_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (wr_fire) begin
        case (wr_off)
          REG_CTRL:    ctrl_q    <= apply_wstrb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_PERIOD:  period_q  <= apply_wstrb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_STEPS:   steps_q   <= steps_merged;
          REG_SCRATCH: scratch_q <= apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
      if (done_pulse)                           done_q <= 1'b1;
      else if (wr_fire && wr_off == REG_CTRL)   done_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_off)
      REG_CTRL:    rd_val = ctrl_q;
      REG_PERIOD:  rd_val = period_q;
      REG_STEPS:   rd_val = steps_q;
      REG_SCRATCH: rd_val = scratch_q;
      REG_STATUS:  rd_val = {30'd0, done_q, busy};
      REG_REMAIN:  rd_val = remain;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      dir_o      <= 1'b0;
      ms_o       <= 3'd0;
      enable_n_o <= 1'b1;
    end else begin
      dir_o      <= ctrl_q[CTRL_DIR];
      ms_o       <= ctrl_q[CTRL_MS_HI:CTRL_MS_LO];
      enable_n_o <= ~ctrl_q[CTRL_EN];
    end
  end

  stepper_pulse_gen #(.PULSE_W(PULSE_W)) u_pulse_gen (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .en         (ctrl_q[CTRL_EN]),
    .period     (period_q),
    .load       (step_load),
    .load_val   (steps_merged),
    .step       (step_o),
    .busy       (busy),
    .done_pulse (done_pulse),
    .remain     (remain)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_pololu_stepper_axi_slave.sv
// Bench for pololu_stepper_axi_slave: AXI BFM tasks, shadow register model and step-train monitor.
module tb_pololu_stepper_axi_slave;

  localparam logic [4:0] A_CTRL = 5'h00, A_PERIOD = 5'h04, A_STEPS = 5'h08, A_SCRATCH = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10, A_REMAIN = 5'h14;
  localparam int PW = 100;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        ARESETN;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        step_o, dir_o, enable_n_o;
  logic [2:0]  ms_o;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] shadow [4];

  pololu_stepper_axi_slave dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .step_o(step_o), .dir_o(dir_o), .enable_n_o(enable_n_o), .ms_o(ms_o)
  );

  // Step-train monitor: rising-edge cycle stamps and high widths.
  int cyc = 0;
  int rise_q[$];
  int high_q[$];
  int hl = 0;
  logic prev_step = 1'b0;
  always @(posedge tb_ACLK) cyc++;
  always @(negedge tb_ACLK) begin
    if (step_o === 1'b1 && prev_step !== 1'b1) rise_q.push_back(cyc);
    if (step_o === 1'b1) hl++;
    else if (prev_step === 1'b1) begin
      high_q.push_back(hl);
      hl = 0;
    end
    prev_step = step_o;
  end

  function automatic logic [31:0] model_merge(input logic [31:0] old_v, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge tb_ACLK);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL aw_timeout addr=%h got no AWREADY want AWREADY", a); end
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL b_timeout addr=%h got no BVALID want BVALID", a); end
    resp = bresp;
    @(posedge tb_ACLK); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge tb_ACLK);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL ar_timeout addr=%h got no ARREADY want ARREADY", a); end
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (rvalid !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL r_timeout addr=%h got no RVALID want RVALID", a); end
    d = rdata; resp = rresp;
    @(posedge tb_ACLK); #1;
    rready = 1'b0;
  endtask

  // Stimulus only: enable with DIR=1, set PERIOD, then launch a move.
  task automatic do_move(input logic [31:0] per, input logic [31:0] nst);
    logic [1:0] r;
    axi_write(A_CTRL, 32'h3, 4'hF, r);
    axi_write(A_PERIOD, per, 4'hF, r);
    rise_q.delete(); high_q.delete();
    axi_write(A_STEPS, nst, 4'hF, r);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    n_total++;
    if ({awready, wready, bvalid, arready, rvalid, step_o, enable_n_o, dir_o, ms_o} !== 11'b00000_0_1_0_000)
      $display("FAIL reset_outputs got %b want 00000010000",
               {awready, wready, bvalid, arready, rvalid, step_o, enable_n_o, dir_o, ms_o});
    else n_pass++;
    n_total++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
    @(negedge tb_ACLK); ARESETN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), d, r);
      n_total++;
      if (d !== 32'h0 || r !== 2'b00) $display("FAIL reset_reg_%0d got %h/%b want 0/00", i, d, r);
      else n_pass++;
    end
  endtask

  task automatic test_regs();
    logic [31:0] d, pat [4], wd;
    logic [4:0]  addrs [4];
    logic [3:0]  s;
    logic [1:0]  r;
    int w;
    pat = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), pat[i], 4'hF, r);
      shadow[i] = pat[i];
      n_total++;
      if (r !== 2'b00) $display("FAIL bresp_%0d got %b want 00", i, r); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r);
      n_total++;
      if (d !== shadow[i] || r !== 2'b00) $display("FAIL readback_%0d got %h want %h", i, d, shadow[i]);
      else n_pass++;
    end
    axi_write(A_CTRL, 32'h0, 4'hF, r);
    shadow[0] = 32'h0;
    addrs = '{A_PERIOD, A_SCRATCH, 5'h18, 5'h1C};
    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(0, 3);
      wd = $urandom;
      s = 4'($urandom);
      axi_write(addrs[w], wd, s, r);
      if (w < 2) shadow[addrs[w] >> 2] = model_merge(shadow[addrs[w] >> 2], wd, s);
      axi_read(addrs[w], d, r);
      n_total++;
      if (d !== ((w < 2) ? shadow[addrs[w] >> 2] : 32'h0))
        $display("FAIL rand_rw_%0d addr=%h got %h want %h", k, addrs[w], d,
                 (w < 2) ? shadow[addrs[w] >> 2] : 32'h0);
      else n_pass++;
    end
  endtask

  task automatic test_wstrb();
    logic [31:0] d, wd;
    logic [3:0]  s;
    logic [1:0]  r;
    axi_write(A_SCRATCH, 32'h11223344, 4'hF, r);
    axi_write(A_SCRATCH, 32'hAABBCCDD, 4'b0010, r);
    axi_read(A_SCRATCH, d, r);
    n_total++;
    if (d !== 32'h1122CC44) $display("FAIL wstrb_fixed got %h want 1122cc44", d); else n_pass++;
    shadow[3] = 32'h1122CC44;
    for (int k = 0; k < 4; k++) begin
      wd = $urandom; s = 4'($urandom);
      axi_write(A_SCRATCH, wd, s, r);
      shadow[3] = model_merge(shadow[3], wd, s);
      axi_read(A_SCRATCH, d, r);
      n_total++;
      if (d !== shadow[3]) $display("FAIL wstrb_rand_%0d strb=%b got %h want %h", k, s, d, shadow[3]);
      else n_pass++;
    end
  endtask

  task automatic test_motion();
    logic [31:0] d; logic [1:0] r;
    do_move(32'd500, 32'd4);
    axi_read(A_STATUS, d, r);
    n_total++;
    if (d !== 32'h1) $display("FAIL motion_status_busy got %h want 1", d); else n_pass++;
    n_total++;
    if ({dir_o, enable_n_o, ms_o} !== 5'b1_0_000) $display("FAIL motion_pins got %b want 10000", {dir_o, enable_n_o, ms_o});
    else n_pass++;
    repeat (4 * 500 + 40) @(negedge tb_ACLK);
    n_total++;
    if (rise_q.size() !== 4 || high_q.size() !== 4)
      $display("FAIL motion_count got %0d/%0d want 4/4", rise_q.size(), high_q.size());
    else n_pass++;
    for (int i = 1; i < rise_q.size(); i++) begin
      n_total++;
      if (rise_q[i] - rise_q[i-1] !== 500) $display("FAIL motion_spacing_%0d got %0d want 500", i, rise_q[i] - rise_q[i-1]);
      else n_pass++;
    end
    foreach (high_q[i]) begin
      n_total++;
      if (high_q[i] !== PW) $display("FAIL motion_width_%0d got %0d want %0d", i, high_q[i], PW); else n_pass++;
    end
    axi_read(A_STATUS, d, r);
    n_total++;
    if (d !== 32'h2) $display("FAIL motion_status_done got %h want 2", d); else n_pass++;
    axi_read(A_REMAIN, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL motion_remain got %h want 0", d); else n_pass++;
  endtask

  task automatic test_clamp();
    logic [31:0] per, nst, eff, d;
    logic [1:0]  r;
    for (int it = 0; it < 3; it++) begin
      per = (it == 0) ? 32'd50 : ((it == 1) ? 32'($urandom_range(100, 260)) : 32'($urandom_range(201, 600)));
      nst = (it == 0) ? 32'd2 : 32'($urandom_range(2, 3));
      eff = (per > 2 * PW) ? per : 2 * PW;
      do_move(per, nst);
      repeat (int'(nst * eff) + 40) @(negedge tb_ACLK);
      n_total++;
      if (rise_q.size() !== int'(nst)) $display("FAIL clamp_count_%0d got %0d want %0d", it, rise_q.size(), nst);
      else n_pass++;
      for (int i = 1; i < rise_q.size(); i++) begin
        n_total++;
        if (rise_q[i] - rise_q[i-1] !== int'(eff))
          $display("FAIL clamp_spacing_%0d per=%0d got %0d want %0d", it, per, rise_q[i] - rise_q[i-1], eff);
        else n_pass++;
      end
      axi_read(A_STATUS, d, r);
      n_total++;
      if (d !== 32'h2) $display("FAIL clamp_status_%0d got %h want 2", it, d); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] d; logic [1:0] r;
    int n;
    do_move(32'd300, 32'd5);
    n = 0;
    while (rise_q.size() < 3 && n < 3000) begin @(negedge tb_ACLK); n++; end
    if (n >= 3000) begin n_total++; $display("FAIL abort_wait got %0d pulses want 3", rise_q.size()); end
    axi_read(A_REMAIN, d, r);
    n_total++;
    if (d !== 32'd3) $display("FAIL abort_remain_before got %0d want 3", d); else n_pass++;
    axi_write(A_CTRL, 32'h0, 4'hF, r);
    n_total++;
    if (step_o !== 1'b0) $display("FAIL abort_step got %b want 0", step_o); else n_pass++;
    axi_read(A_STATUS, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL abort_status got %h want 0", d); else n_pass++;
    axi_read(A_REMAIN, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL abort_remain got %h want 0", d); else n_pass++;
    n_total++;
    if (enable_n_o !== 1'b1) $display("FAIL abort_enable_n got %b want 1", enable_n_o); else n_pass++;
    repeat (400) @(negedge tb_ACLK);
    n_total++;
    if (rise_q.size() !== 3) $display("FAIL abort_no_more got %0d pulses want 3", rise_q.size()); else n_pass++;
  endtask

  task automatic test_zero_en0();
    logic [31:0] d; logic [1:0] r;
    do_move(32'd200, 32'd1);
    repeat (240) @(negedge tb_ACLK);
    axi_write(A_STEPS, 32'h0, 4'hF, r);
    repeat (10) @(negedge tb_ACLK);
    axi_read(A_STATUS, d, r);
    n_total++;
    if (d !== 32'h2 || rise_q.size() !== 1) $display("FAIL steps_zero got status %h pulses %0d want 2/1", d, rise_q.size());
    else n_pass++;
    axi_write(A_CTRL, 32'h0, 4'hF, r);
    rise_q.delete();
    axi_write(A_STEPS, 32'd7, 4'hF, r);
    repeat (300) @(negedge tb_ACLK);
    axi_read(A_STATUS, d, r);
    n_total++;
    if (d !== 32'h0 || rise_q.size() !== 0) $display("FAIL en0_nomove got status %h pulses %0d want 0/0", d, rise_q.size());
    else n_pass++;
    axi_read(A_STEPS, d, r);
    n_total++;
    if (d !== 32'd7) $display("FAIL en0_steps_stored got %h want 7", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, x, y; logic [1:0] r;
    int n, held;
    axi_read(5'h1C, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL read_1c got %h/%b want 0/00", d, r); else n_pass++;
    x = $urandom; y = $urandom;
    @(negedge tb_ACLK);
    awaddr = A_SCRATCH; wdata = x; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL b2b_aw1 got no AWREADY want AWREADY"); end
    @(posedge tb_ACLK); #1;
    awaddr = A_PERIOD; wdata = y;
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tb_ACLK);
      if (bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0) held++;
    end
    n_total++;
    if (held !== 10) $display("FAIL b_hold got %0d held cycles want 10", held); else n_pass++;
    bready = 1'b1;
    @(posedge tb_ACLK); #1;
    bready = 1'b0;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL b2b_aw2 got no AWREADY want AWREADY"); end
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
    if (n >= 100) begin n_total++; $display("FAIL b2b_b2 got no BVALID want BVALID"); end
    @(posedge tb_ACLK); #1;
    bready = 1'b0;
    axi_read(A_SCRATCH, d, r);
    n_total++;
    if (d !== x) $display("FAIL b2b_first got %h want %h", d, x); else n_pass++;
    axi_read(A_PERIOD, d, r);
    n_total++;
    if (d !== y) $display("FAIL b2b_second got %h want %h", d, y); else n_pass++;
  endtask

  task automatic test_reset_mid_move();
    logic [31:0] d; logic [1:0] r;
    int n;
    do_move(32'd300, 32'd10);
    n = 0;
    while (step_o !== 1'b1 && n < 500) begin @(negedge tb_ACLK); n++; end
    if (n >= 500) begin n_total++; $display("FAIL rst_mid_wait got no step want step"); end
    #2 ARESETN = 1'b0;
    #1;
    n_total++;
    if ({step_o, enable_n_o, dir_o} !== 3'b010) $display("FAIL rst_mid_pins got %b want 010", {step_o, enable_n_o, dir_o});
    else n_pass++;
    @(negedge tb_ACLK); ARESETN = 1'b1;
    axi_read(A_STEPS, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL rst_mid_steps got %h want 0", d); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    test_reset();
    test_regs();
    test_wstrb();
    test_motion();
    test_clamp();
    test_abort();
    test_zero_en0();
    test_back_to_back();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
